// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate divider, h/v counters, sync and blanking, and a small
// pattern source (framebuffer pass-through, solid colour, colour bars, checkerboard).
// Colour, sync and de are registered from the pre-update counters, so they trail the
// counter position (pix_req/pix_x/pix_y) by exactly one pixel.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned XW       = 11,
  parameter int unsigned YW       = 10
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  input  logic [3*COLOR_W-1:0]   pix_rgb,
  output logic                   pix_req,
  output logic [XW-1:0]          pix_x,
  output logic [YW-1:0]          pix_y,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   de,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [XW-1:0] H_SS   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SE   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_SS   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SE   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0] BAR_WX = XW'(BAR_W);
  localparam logic [XW-1:0] BAR_MX = XW'(7);

  localparam int unsigned CW = COLOR_W;

  logic            w_pix_en;
  logic [XW-1:0]   r_h_cnt, w_h_nxt;
  logic [YW-1:0]   r_v_cnt, w_v_nxt;
  logic            w_h_wrap, w_v_wrap;
  logic            w_hs_win, w_vs_win;
  logic [XW-1:0]   w_bar_idx;
  logic [2:0]      w_bar;
  logic [3*CW-1:0] w_rgb;
  logic [3*CW-1:0] r_rgb;
  logic            r_de, r_hs, r_vs, r_line_start, r_frame_start;

  if (CLK_DIV <= 1) begin : g_nodiv
    assign w_pix_en = 1'b1;
  end else begin : g_div
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    logic [DW-1:0] r_div;

    // Pixel divider: one pix_en clock every CLK_DIV clocks.
    always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
        r_div <= '0;
      end else if (r_div == DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end

    assign w_pix_en = (r_div == DIV_LAST);
  end

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  // Raster position next-state: h advances every pixel, v advances on h wrap.
  always_comb begin
    w_h_nxt = r_h_cnt;
    w_v_nxt = r_v_cnt;
    if (w_pix_en) begin
      if (w_h_wrap) begin
        w_h_nxt = '0;
        w_v_nxt = w_v_wrap ? '0 : r_v_cnt + YW'(1);
      end else begin
        w_h_nxt = r_h_cnt + XW'(1);
      end
    end
  end

  // Raster position registers.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  assign pix_req  = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign pix_x    = pix_req ? r_h_cnt : '0;
  assign pix_y    = pix_req ? r_v_cnt : '0;
  assign w_hs_win = (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
  assign w_vs_win = (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);

  // Colour for the current counter position; bar index saturates at the last (black) bar
  // when H_ACTIVE is not a multiple of eight.
  always_comb begin
    w_bar_idx = r_h_cnt / BAR_WX;
    w_bar     = (w_bar_idx > BAR_MX) ? 3'd7 : w_bar_idx[2:0];
    w_rgb     = '0;
    case (mode)
      2'd0: w_rgb = pix_rgb;
      2'd1: w_rgb = solid_rgb;
      // Bar order white..black maps to R=~b[1], G=~b[2], B=~b[0].
      2'd2: w_rgb = {{CW{~w_bar[1]}}, {CW{~w_bar[2]}}, {CW{~w_bar[0]}}};
      default: w_rgb = {3*CW{r_h_cnt[5] ^ r_v_cnt[5]}};
    endcase
  end

  // Output pixel register: updated only on pix_en so each pixel is held for CLK_DIV clocks.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_rgb         <= '0;
      r_de          <= 1'b0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_pix_en) begin
      r_rgb         <= pix_req ? w_rgb : '0;
      r_de          <= pix_req;
      r_hs          <= w_hs_win ? HS_POL : ~HS_POL;
      r_vs          <= w_vs_win ? VS_POL : ~VS_POL;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign VGA_R       = r_rgb[3*CW-1:2*CW];
  assign VGA_G       = r_rgb[2*CW-1:CW];
  assign VGA_B       = r_rgb[CW-1:0];
  assign de          = r_de;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
